// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM pipeline stage and its data array.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEPTH_DEF   = 256;
  localparam int LATENCY_DEF = 3;

  // Value cnt is loaded with on entry to BUSY; BUSY then lasts LATENCY-1 cycles.
  function automatic logic [3:0] busy_start(input int lat);
    return 4'(lat - 2);
  endfunction

endpackage

// File: rtl/mem_stage_dmem_array.sv
// Single-port data memory: DEPTH x 32, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage with a multi-cycle data memory and MEM/WB register.
// Optional misaligned-access trapping via `MEM_MISALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] ALUOut_i,
  input  logic [31:0] mux7_i,
  input  logic [4:0]  mux3_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        stall_o,
  output logic [1:0]  WB_o,
  output logic [31:0] ALUOut_o,
  output logic [31:0] ReadData_o,
  output logic [4:0]  mux3_o,
  output logic        misalign_o
);

  localparam int AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req, misal, acc;
  logic        mem_we, rd_sel;
  logic [31:0] mem_rdata, rd_data;
  logic [1:0]  wb_q, wb_d;
  logic [31:0] alu_q, alu_d, rdd_q, rdd_d;
  logic [4:0]  rg_q, rg_d;
  logic        unused_addr;

  // Bits outside the word index are intentionally dropped (address wrap).
  assign unused_addr = ^ALUOut_i;

  assign req = MemRead_i | MemWrite_i;

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis_q;

  assign misal = req & (ALUOut_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mis_q <= 1'b0;
    else       mis_q <= mis_q | misal;
  end

  assign misalign_o = mis_q;
`else
  assign misal      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign acc = req & ~misal;

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = busy_start(LATENCY);
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Reset masks stall since a request may be present while rst_i is high.
  always_comb begin
    stall_o = 1'b0;
    mem_we  = 1'b0;
    rd_sel  = 1'b0;
    if (!rst_i) begin
      stall_o = ((state_q == IDLE) & acc) | (state_q == BUSY);
      mem_we  = (state_q == DONE) & MemWrite_i;
      rd_sel  = (state_q == DONE) & MemRead_i & ~MemWrite_i;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (ALUOut_i[AW+1:2]),
    .wdata_i (mux7_i),
    .rdata_o (mem_rdata)
  );

  assign rd_data = rd_sel ? mem_rdata : 32'd0;

  // MEM/WB register: bubble on stall, load otherwise.
  always_comb begin
    wb_d  = wb_q;
    alu_d = alu_q;
    rdd_d = rdd_q;
    rg_d  = rg_q;
    if (stall_o) begin
      wb_d = 2'b00;
    end else begin
      wb_d  = misal ? 2'b00 : WB_i;
      alu_d = ALUOut_i;
      rdd_d = rd_data;
      rg_d  = mux3_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q  <= 2'b00;
      alu_q <= 32'd0;
      rdd_q <= 32'd0;
      rg_q  <= 5'd0;
    end else begin
      wb_q  <= wb_d;
      alu_q <= alu_d;
      rdd_q <= rdd_d;
      rg_q  <= rg_d;
    end
  end

  assign WB_o       = wb_q;
  assign ALUOut_o   = alu_q;
  assign ReadData_o = rdd_q;
  assign mux3_o     = rg_q;

endmodule
